// File: rtl/vectadd_mul_arbiter.sv
// vectadd_mul_arbiter
// Shares one two-stage 32x32->64 multiplier cell between two vector-add lane
// requesters. One request is granted per cycle. Two valid/id pairs follow the
// operands through the cell's input register and then its output register.
// The product is returned on a single response channel that supports backpressure.
//
// Optional build macro: VECTADD_MUL_ARB_RR_EN
//   defined   -> round-robin tie-break between the two requesters
//   undefined -> fixed priority, requester 0 always wins a tie

module vectadd_mul_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,

  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*WIDTH-1:0]   req_src1_i,
  input  logic [2*WIDTH-1:0]   req_src2_i,
  input  logic [1:0]           req_signed1_i,
  input  logic [1:0]           req_signed2_i,

  output logic [WIDTH-1:0]     mul_src1_o,
  output logic [WIDTH-1:0]     mul_src2_o,
  output logic                 mul_signa_o,
  output logic                 mul_signb_o,
  output logic                 mul_in_en_o,
  output logic                 mul_out_en_o,
  input  logic [2*WIDTH-1:0]   mul_result_i,

  output logic                 rsp_valid_o,
  output logic                 rsp_id_o,
  output logic [2*WIDTH-1:0]   rsp_data_o,
  input  logic                 rsp_ready_i,

  output logic                 busy_o
);

  // Stage 1: an operand pair sits in the cell input registers.
  logic v1_q, v1_d;
  logic id1_q, id1_d;
  // Stage 2: a product sits in the cell output register.
  logic v2_q, v2_d;
  logic id2_q, id2_d;

  // Grant decision for the current cycle.
  logic [1:0] grant;
  logic       gnt_idx;
  logic       xfer;

`ifdef VECTADD_MUL_ARB_RR_EN
  // Index of the most recently granted requester. On a tie, the other requester wins.
  logic last_q, last_d;
`endif

  // Pipeline enables: the output stage moves when it is empty or being drained.
  // The input stage moves when it is empty or its contents move forward.
  assign mul_out_en_o = !v2_q | rsp_ready_i;
  assign mul_in_en_o  = !v1_q | mul_out_en_o;

  // Pick at most one requester, and only when stage 1 can take a new operand pair.
  always_comb begin
    grant   = 2'b00;
    gnt_idx = 1'b0;
    if (mul_in_en_o && reset_n_i) begin
      case (req_valid_i)
        2'b01: begin
          grant   = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          grant   = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
`ifdef VECTADD_MUL_ARB_RR_EN
          gnt_idx = ~last_q;
          grant   = last_q ? 2'b01 : 2'b10;
`else
          gnt_idx = 1'b0;
          grant   = 2'b01;
`endif
        end
        default: begin
          grant   = 2'b00;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = grant;
  assign xfer        = |(req_valid_i & grant);

  // Route the granted requester's operands and sign flags to the cell.
  // When nothing is granted, requester 0 is selected.
  assign mul_src1_o  = gnt_idx ? req_src1_i[WIDTH +: WIDTH] : req_src1_i[0 +: WIDTH];
  assign mul_src2_o  = gnt_idx ? req_src2_i[WIDTH +: WIDTH] : req_src2_i[0 +: WIDTH];
  assign mul_signa_o = gnt_idx ? req_signed1_i[1] : req_signed1_i[0];
  assign mul_signb_o = gnt_idx ? req_signed2_i[1] : req_signed2_i[0];

  // Stage tracking follows the same enables as the cell registers, so it stays in step with them.
  always_comb begin
    v1_d  = v1_q;
    id1_d = id1_q;
    v2_d  = v2_q;
    id2_d = id2_q;
    if (mul_in_en_o) begin
      v1_d  = xfer;
      id1_d = gnt_idx;
    end
    if (mul_out_en_o) begin
      v2_d  = v1_q;
      id2_d = id1_q;
    end
  end

  // Stage valid/id registers. Reset drops any product in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1_q  <= 1'b0;
      id1_q <= 1'b0;
      v2_q  <= 1'b0;
      id2_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      id1_q <= id1_d;
      v2_q  <= v2_d;
      id2_q <= id2_d;
    end
  end

`ifdef VECTADD_MUL_ARB_RR_EN
  // The pointer records whoever actually transferred. After reset it points at 1, so requester 0 wins first.
  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = gnt_idx;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // The response is the cell output register itself, tagged with the id of its owner.
  assign rsp_valid_o = v2_q;
  assign rsp_id_o    = id2_q;
  assign rsp_data_o  = mul_result_i;
  assign busy_o      = v1_q | v2_q;

endmodule

// File: tb/tb_vectadd_mul_arbiter.sv
// tb_vectadd_mul_arbiter
// Directed bench for vectadd_mul_arbiter. It includes a behavioural model of the
// two-stage multiplier cell: input registers gated by mul_in_en and an output
// register gated by mul_out_en.
// Tie-break expectations follow VECTADD_MUL_ARB_RR_EN.

`timescale 1ns/1ps

module tb_vectadd_mul_arbiter;

   logic        clk;
   logic        resetN;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [63:0] reqSrc1;
   logic [63:0] reqSrc2;
   logic [1:0]  reqSigned1;
   logic [1:0]  reqSigned2;
   logic [31:0] mulSrc1;
   logic [31:0] mulSrc2;
   logic        mulSignA;
   logic        mulSignB;
   logic        mulInEn;
   logic        mulOutEn;
   logic [63:0] mulResult;
   logic        rspValid;
   logic        rspId;
   logic [63:0] rspData;
   logic        rspReady;
   logic        busy;

   int checkCount;
   int failCount;

   vectadd_mul_arbiter #(.WIDTH(32)) dut (
      .clk_i        (clk),
      .reset_n_i    (resetN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_src1_i   (reqSrc1),
      .req_src2_i   (reqSrc2),
      .req_signed1_i(reqSigned1),
      .req_signed2_i(reqSigned2),
      .mul_src1_o   (mulSrc1),
      .mul_src2_o   (mulSrc2),
      .mul_signa_o  (mulSignA),
      .mul_signb_o  (mulSignB),
      .mul_in_en_o  (mulInEn),
      .mul_out_en_o (mulOutEn),
      .mul_result_i (mulResult),
      .rsp_valid_o  (rspValid),
      .rsp_id_o     (rspId),
      .rsp_data_o   (rspData),
      .rsp_ready_i  (rspReady),
      .busy_o       (busy)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the multiplier cell. It has no reset, like the real hard block.
   logic [31:0] cellA;
   logic [31:0] cellB;
   logic        cellSa;
   logic        cellSb;

   function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = {{32{sa & a[31]}}, a};
      eb = {{32{sb & b[31]}}, b};
      return ea * eb;
   endfunction

   // Input stage captures the operand pair. Output stage captures the product of the previous pair.
   always @(posedge clk) begin
      if (mulInEn) begin
         cellA  <= mulSrc1;
         cellB  <= mulSrc2;
         cellSa <= mulSignA;
         cellSb <= mulSignB;
      end
      if (mulOutEn) begin
         mulResult <= mulModel(cellA, cellB, cellSa, cellSb);
      end
   end

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive every requester and response input, then let the combinational paths settle.
   task automatic applyStimulus(input logic [1:0] valid, input logic [63:0] src1, input logic [63:0] src2,
                                input logic [1:0] s1, input logic [1:0] s2, input logic ready);
      reqValid   = valid;
      reqSrc1    = src1;
      reqSrc2    = src2;
      reqSigned1 = s1;
      reqSigned2 = s2;
      rspReady   = ready;
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic stepClock;
      @(posedge clk);
      #1;
   endtask

   // Tie-break order expected for four cycles of contention.
`ifdef VECTADD_MUL_ARB_RR_EN
   logic tieIds [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
   logic tieIds [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

   // Backpressure schedule, one entry per cycle.
   logic        bpReady    [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
   logic        bpValid    [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
   int          bpOp       [9] = '{0, 1, 2, 2, 2, 2, 0, 0, 0};
   logic [1:0]  bpExpReady [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
   logic        bpExpValid [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
   int          bpExpIdx   [9] = '{0, 0, 0, 0, 0, 0, 1, 2, 0};
   logic [31:0] bpA        [3] = '{32'd3, 32'd5, 32'd7};
   logic [31:0] bpB        [3] = '{32'd4, 32'd6, 32'd8};
   logic [63:0] bpProd     [3] = '{64'd12, 64'd30, 64'd56};

   // Guard against a run that never finishes.
   initial begin
      #100000;
      failCount++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   // Directed test sequence
   initial begin
      checkCount = 0;
      failCount  = 0;
      resetN     = 1'b0;
      applyStimulus(2'b11, 64'd0, 64'd0, 2'b00, 2'b00, 1'b0);

      $display("[TB] reset values");
      checkOutput("rst_rsp_valid", rspValid, 1'b0);
      checkOutput("rst_rsp_id", rspId, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_req_ready", reqReady, 2'b00);
      checkOutput("rst_in_en", mulInEn, 1'b1);
      checkOutput("rst_out_en", mulOutEn, 1'b1);
      stepClock();
      stepClock();
      resetN = 1'b1;
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      stepClock();

      $display("[TB] single unsigned op");
      applyStimulus(2'b01, {32'd0, 32'd7}, {32'd0, 32'd6}, 2'b00, 2'b00, 1'b1);
      checkOutput("single_ready", reqReady, 2'b01);
      stepClock();
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      checkOutput("single_busy", busy, 1'b1);
      checkOutput("single_early_valid", rspValid, 1'b0);
      stepClock();
      checkOutput("single_valid", rspValid, 1'b1);
      checkOutput("single_id", rspId, 1'b0);
      checkOutput("single_data", rspData, 64'd42);
      stepClock();
      checkOutput("single_drained", rspValid, 1'b0);

      $display("[TB] signed op on requester 1");
      applyStimulus(2'b10, {32'hFFFF_FFFE, 32'd0}, {32'd3, 32'd0}, 2'b10, 2'b10, 1'b1);
      checkOutput("signed_ready", reqReady, 2'b10);
      stepClock();
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      stepClock();
      checkOutput("signed_valid", rspValid, 1'b1);
      checkOutput("signed_id", rspId, 1'b1);
      checkOutput("signed_data", rspData, 64'hFFFF_FFFF_FFFF_FFFA);
      stepClock();
      checkOutput("signed_drained", rspValid, 1'b0);

      $display("[TB] tie between requesters");
      for (int c = 0; c < 6; c++) begin
         applyStimulus((c < 4) ? 2'b11 : 2'b00, {32'd5, 32'd2}, {32'd7, 32'd3}, 2'b00, 2'b00, 1'b1);
         if (c < 4) begin
            checkOutput("tie_ready", reqReady, tieIds[c] ? 2'b10 : 2'b01);
         end
         if (c >= 2) begin
            checkOutput("tie_rsp_valid", rspValid, 1'b1);
            checkOutput("tie_rsp_id", rspId, tieIds[c-2]);
            checkOutput("tie_rsp_data", rspData, tieIds[c-2] ? 64'd35 : 64'd6);
         end else begin
            checkOutput("tie_rsp_early", rspValid, 1'b0);
         end
         stepClock();
      end
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      checkOutput("tie_drained", rspValid, 1'b0);

      $display("[TB] backpressure");
      for (int c = 0; c < 9; c++) begin
         applyStimulus(bpValid[c] ? 2'b01 : 2'b00, {32'd0, bpA[bpOp[c]]}, {32'd0, bpB[bpOp[c]]},
                       2'b00, 2'b00, bpReady[c]);
         checkOutput("bp_ready", reqReady, bpExpReady[c]);
         checkOutput("bp_rsp_valid", rspValid, bpExpValid[c]);
         if (bpExpValid[c]) begin
            checkOutput("bp_rsp_id", rspId, 1'b0);
            checkOutput("bp_rsp_data", rspData, bpProd[bpExpIdx[c]]);
         end
         if (c >= 2 && c <= 4) begin
            checkOutput("bp_in_en", mulInEn, 1'b0);
            checkOutput("bp_out_en", mulOutEn, 1'b0);
         end
         stepClock();
      end

      $display("[TB] reset mid-flight");
      applyStimulus(2'b01, {32'd0, 32'd9}, {32'd0, 32'd9}, 2'b00, 2'b00, 1'b0);
      checkOutput("mid_ready0", reqReady, 2'b01);
      stepClock();
      applyStimulus(2'b01, {32'd0, 32'd10}, {32'd0, 32'd10}, 2'b00, 2'b00, 1'b0);
      checkOutput("mid_ready1", reqReady, 2'b01);
      stepClock();
      applyStimulus(2'b01, {32'd0, 32'd11}, {32'd0, 32'd11}, 2'b00, 2'b00, 1'b0);
      checkOutput("mid_full_valid", rspValid, 1'b1);
      checkOutput("mid_full_data", rspData, 64'd81);
      resetN = 1'b0;
      #1;
      checkOutput("mid_rst_valid", rspValid, 1'b0);
      checkOutput("mid_rst_busy", busy, 1'b0);
      checkOutput("mid_rst_ready", reqReady, 2'b00);
      stepClock();
      resetN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
         checkOutput("post_rst_no_rsp", rspValid, 1'b0);
         checkOutput("post_rst_busy", busy, 1'b0);
         stepClock();
      end
      applyStimulus(2'b11, {32'd13, 32'd11}, {32'd14, 32'd12}, 2'b00, 2'b00, 1'b1);
      checkOutput("post_rst_tie", reqReady, 2'b01);
      stepClock();
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      stepClock();
      checkOutput("post_rst_valid", rspValid, 1'b1);
      checkOutput("post_rst_id", rspId, 1'b0);
      checkOutput("post_rst_data", rspData, 64'd132);
      stepClock();
      checkOutput("post_rst_drained", rspValid, 1'b0);

      $display("[TB] throughput");
      for (int c = 0; c < 18; c++) begin
         applyStimulus((c < 16) ? 2'b01 : 2'b00, {32'd0, 32'(c + 1)}, {32'd0, 32'(c + 2)},
                       2'b00, 2'b00, 1'b1);
         if (c < 16) begin
            checkOutput("tp_ready", reqReady, 2'b01);
         end
         if (c >= 2) begin
            checkOutput("tp_rsp_valid", rspValid, 1'b1);
            checkOutput("tp_rsp_data", rspData, 64'((c - 1) * c));
         end else begin
            checkOutput("tp_rsp_early", rspValid, 1'b0);
         end
         stepClock();
      end
      applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 2'b00, 1'b1);
      checkOutput("tp_drained", rspValid, 1'b0);
      checkOutput("tp_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
